// File: rtl/nonoverlap_mealy_fsm.sv
// Serial 1011 sequence detector, Mealy style, non-overlapping.
// The detect flag is combinational from the current state and the current input bit.
module nonoverlap_mealy_fsm (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      S1   = 2'b01,
      S10  = 2'b10,
      S101 = 2'b11
   } state_t;

   state_t state, state_nxt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: defaults come first so every path assigns both outputs and no latch is inferred.
   always_comb begin
      state_nxt = IDLE;
      out       = 1'b0;
      case (state)
         IDLE: state_nxt = in ? S1 : IDLE;
         S1:   state_nxt = in ? S1 : S10;
         S10:  state_nxt = in ? S101 : IDLE;
         S101: begin
            // A match restarts from IDLE, so its bits never seed the next pattern.
            state_nxt = in ? IDLE : S10;
            out       = in && !reset;
         end
         default: begin
            state_nxt = IDLE;
            out       = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_nonoverlap_mealy_fsm.sv
// Self-checking bench for nonoverlap_mealy_fsm: directed sequences plus a random
// stream checked against a history-window reference model through a scoreboard.
module tb_nonoverlap_mealy_fsm;

   logic clk = 1'b0;
   logic reset;
   logic in;
   logic out;

   typedef struct {
      logic  exp;
      string name;
      int    idx;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   nonoverlap_mealy_fsm dut (
      .clk   (clk),
      .reset (reset),
      .in    (in),
      .out   (out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Drive one bit after the falling edge, queue the expectation, and compare out
   // well before the rising edge that consumes the bit.
   task automatic apply(input logic b, input logic r, input logic e,
                        input string nm, input int i);
      exp_t item;
      @(negedge clk);
      in    = b;
      reset = r;
      item.exp  = e;
      item.name = nm;
      item.idx  = i;
      sb.push_back(item);
      #2;
      item = sb.pop_front();
      vectors++;
      if (out !== item.exp) begin
         miscompares++;
         $display("FAIL %s bit %0d: out=%b expected=%b", item.name, item.idx, out, item.exp);
      end
   endtask

   // bits: '0'/'1' data with reset low, 'r' means reset high with in=1.
   // exps: expected out per bit.
   task automatic run_seq(input string bits, input string exps, input string nm);
      for (int i = 0; i < bits.len(); i++) begin
         logic b, r, e;
         r = (bits[i] == "r");
         b = r ? 1'b1 : (bits[i] == "1");
         e = (exps[i] == "1");
         apply(b, r, e, nm, i);
      end
   endtask

   task automatic test_reset;
      run_seq("rr", "00", "reset_hold");
      run_seq("1011", "0001", "reset_then_match");
   endtask

   task automatic test_no_match;
      run_seq("0100", "0000", "no_match");
      run_seq("1011", "0001", "no_match_idle_check");
   endtask

   task automatic test_single_match;
      run_seq("1011", "0001", "single_match");
      run_seq("011", "000", "post_match_idle");
   endtask

   task automatic test_non_overlap;
      run_seq("0", "0", "flush");
      run_seq("1011011", "0001000", "non_overlap");
      run_seq("1011", "0001", "non_overlap_fresh");
   endtask

   task automatic test_fallback;
      run_seq("0", "0", "flush");
      run_seq("101011", "000001", "fallback_s101_to_s10");
      run_seq("11011", "00001", "fallback_s1_stay");
      run_seq("10011", "00000", "fallback_s10_to_idle");
   endtask

   task automatic test_reset_mid_pattern;
      run_seq("0", "0", "flush");
      run_seq("101r1", "00000", "reset_mid_pattern");
      run_seq("011", "001", "reset_mid_complete");
   endtask

   task automatic test_back_to_back;
      run_seq("0", "0", "flush");
      run_seq("10111011", "00010001", "back_to_back");
   endtask

   // Reference: a match is the last four bits seen since the latest reset or
   // match being 1011; both reset and a match clear the history.
   task automatic test_random;
      logic [3:0] hist = 4'b0000;
      int         cnt  = 0;
      reset = 1'b1;
      apply(1'b1, 1'b1, 1'b0, "random_init", 0);
      for (int i = 0; i < 400; i++) begin
         logic b, r, e;
         r = ($urandom_range(0, 39) == 0);
         b = ($urandom_range(0, 99) < 60);
         e = 1'b0;
         if (r) begin
            hist = 4'b0000;
            cnt  = 0;
         end else begin
            hist = {hist[2:0], b};
            cnt  = cnt + 1;
            if (cnt >= 4 && hist == 4'b1011) begin
               e    = 1'b1;
               hist = 4'b0000;
               cnt  = 0;
            end
         end
         apply(b, r, e, "random", i);
      end
   endtask

   initial begin
      reset = 1'b1;
      in    = 1'b1;
      test_reset();
      test_no_match();
      test_single_match();
      test_non_overlap();
      test_fallback();
      test_reset_mid_pattern();
      test_back_to_back();
      test_random();
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: entries=%0d expected=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
